axil_qid_map_regs: RTL

AXIL_QID_MAP_REGS -- requirements
Module: axil_qid_map_regs

---
 rtl/axil_qid_map_regs.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_qid_map_regs.sv
// AXI4-Lite register block: ID, SCRATCH, ERRCNT and per-function queue ID map registers (base/count).
// Define AXIL_WSTRB_EN to add the s_axil_wstrb port and byte-granular register writes.

module axil_qid_map_regs #(
    parameter int NUM_PHYS_FUNC = 2
) (
    input  logic                         axil_aclk,
    input  logic                         axil_aresetn,

    input  logic                         s_axil_awvalid,
    input  logic [31:0]                  s_axil_awaddr,
    output logic                         s_axil_awready,

    input  logic                         s_axil_wvalid,
    input  logic [31:0]                  s_axil_wdata,
`ifdef AXIL_WSTRB_EN
    input  logic [3:0]                   s_axil_wstrb,
`endif
    output logic                         s_axil_wready,

    output logic                         s_axil_bvalid,
    output logic [1:0]                   s_axil_bresp,
    input  logic                         s_axil_bready,

    input  logic                         s_axil_arvalid,
    input  logic [31:0]                  s_axil_araddr,
    output logic                         s_axil_arready,

    output logic                         s_axil_rvalid,
    output logic [31:0]                  s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    input  logic                         s_axil_rready,

    output logic [NUM_PHYS_FUNC*16-1:0]  q_base,
    output logic [NUM_PHYS_FUNC*16-1:0]  q_num,
    output logic [NUM_PHYS_FUNC-1:0]     cfg_update
);

    localparam logic [31:0] ID_VALUE     = 32'h4D4E_4943;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [1:0]  RESP_DECERR  = 2'b11;
    localparam logic [29:0] ID_WORD      = 30'h0;
    localparam logic [29:0] SCRATCH_WORD = 30'h1;
    localparam logic [29:0] ERRCNT_WORD  = 30'h2;

    typedef enum logic [1:0] {
        IDLE,
        HAVE_AW,
        HAVE_W,
        RESP
    } wr_state_t;

    // Word address of QMAP_i: byte address 0x1000*(i+1) with the two byte-lane bits dropped.
    function automatic logic [29:0] qmap_word(input int idx);
        return 30'((idx + 1) * 1024);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return result;
    endfunction

    wr_state_t                wr_state;
    logic                     awready_q;
    logic                     wready_q;
    logic                     bvalid_q;
    logic [1:0]               bresp_q;
    logic [NUM_PHYS_FUNC-1:0] cfg_update_q;
    logic [29:0]              aw_word_q;
    logic [31:0]              w_data_q;

    logic                     rvalid_q;
    logic [31:0]              rdata_q;
    logic [1:0]               rresp_q;

    logic [31:0]              scratch;
    logic [31:0]              errcnt;
    logic [31:0]              qmap [NUM_PHYS_FUNC];

    logic                     aw_hs;
    logic                     w_hs;
    logic                     ar_hs;
    logic                     wr_commit;
    logic [29:0]              wr_word;
    logic [31:0]              wr_data;
    logic [3:0]               wr_strb;
    logic [1:0]               wr_resp;
    logic                     wr_scratch_hit;
    logic [NUM_PHYS_FUNC-1:0] wr_qmap_hit;
    logic                     wr_err;

    logic [29:0]              rd_word;
    logic [31:0]              rd_data;
    logic [1:0]               rd_resp;
    logic                     rd_err;

    logic [1:0]               err_inc;
    logic [32:0]              errcnt_sum;
    logic [31:0]              errcnt_next;

    logic                     unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign cfg_update     = cfg_update_q;

    assign s_axil_arready = !rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

    assign aw_hs = s_axil_awvalid && awready_q;
    assign w_hs  = s_axil_wvalid && wready_q;
    assign ar_hs = s_axil_arvalid && !rvalid_q;

    // The write completes on whichever handshake supplies the last missing half.
    assign wr_commit = ((wr_state == IDLE)    && aw_hs && w_hs) ||
                       ((wr_state == HAVE_AW) && w_hs) ||
                       ((wr_state == HAVE_W)  && aw_hs);

    assign wr_word = (wr_state == HAVE_AW) ? aw_word_q : s_axil_awaddr[31:2];
    assign wr_data = (wr_state == HAVE_W)  ? w_data_q  : s_axil_wdata;

`ifdef AXIL_WSTRB_EN
    logic [3:0] w_strb_q;
    assign wr_strb = (wr_state == HAVE_W) ? w_strb_q : s_axil_wstrb;
`else
    assign wr_strb = 4'hF;
`endif

    always_comb begin
        wr_resp        = RESP_DECERR;
        wr_scratch_hit = 1'b0;
        wr_qmap_hit    = '0;
        if (wr_word == ID_WORD || wr_word == ERRCNT_WORD) begin
            wr_resp = RESP_SLVERR;
        end else if (wr_word == SCRATCH_WORD) begin
            wr_resp        = RESP_OKAY;
            wr_scratch_hit = 1'b1;
        end else begin
            for (int i = 0; i < NUM_PHYS_FUNC; i++) begin
                if (wr_word == qmap_word(i)) begin
                    wr_resp        = RESP_OKAY;
                    wr_qmap_hit[i] = 1'b1;
                end
            end
        end
    end

    assign rd_word = s_axil_araddr[31:2];

    always_comb begin
        rd_data = 32'h0;
        rd_resp = RESP_DECERR;
        if (rd_word == ID_WORD) begin
            rd_data = ID_VALUE;
            rd_resp = RESP_OKAY;
        end else if (rd_word == SCRATCH_WORD) begin
            rd_data = scratch;
            rd_resp = RESP_OKAY;
        end else if (rd_word == ERRCNT_WORD) begin
            rd_data = errcnt;
            rd_resp = RESP_OKAY;
        end else begin
            for (int i = 0; i < NUM_PHYS_FUNC; i++) begin
                if (rd_word == qmap_word(i)) begin
                    rd_data = qmap[i];
                    rd_resp = RESP_OKAY;
                end
            end
        end
    end

    assign wr_err = wr_commit && (wr_resp != RESP_OKAY);
    assign rd_err = ar_hs && (rd_resp != RESP_OKAY);

    // A read error and a write error in the same cycle both count.
    assign err_inc     = {1'b0, rd_err} + {1'b0, wr_err};
    assign errcnt_sum  = {1'b0, errcnt} + {31'd0, err_inc};
    assign errcnt_next = errcnt_sum[32] ? 32'hFFFF_FFFF : errcnt_sum[31:0];

    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            wr_state     <= IDLE;
            awready_q    <= 1'b1;
            wready_q     <= 1'b1;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            cfg_update_q <= '0;
            aw_word_q    <= '0;
            w_data_q     <= '0;
`ifdef AXIL_WSTRB_EN
            w_strb_q     <= '0;
`endif
        end else begin
            cfg_update_q <= '0;
            case (wr_state)
                IDLE: begin
                    if (aw_hs && !w_hs) begin
                        aw_word_q <= s_axil_awaddr[31:2];
                        wr_state  <= HAVE_AW;
                        awready_q <= 1'b0;
                    end else if (w_hs && !aw_hs) begin
                        w_data_q <= s_axil_wdata;
`ifdef AXIL_WSTRB_EN
                        w_strb_q <= s_axil_wstrb;
`endif
                        wr_state <= HAVE_W;
                        wready_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (bvalid_q && s_axil_bready) begin
                        wr_state  <= IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
            // The update pulse lands in the first bvalid cycle of the same write.
            if (wr_commit) begin
                wr_state     <= RESP;
                awready_q    <= 1'b0;
                wready_q     <= 1'b0;
                bvalid_q     <= 1'b1;
                bresp_q      <= wr_resp;
                cfg_update_q <= wr_qmap_hit;
            end
        end
    end

    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            scratch <= '0;
            errcnt  <= '0;
            for (int i = 0; i < NUM_PHYS_FUNC; i++) begin
                qmap[i] <= '0;
            end
        end else begin
            if (wr_commit && wr_scratch_hit) begin
                scratch <= merge_bytes(scratch, wr_data, wr_strb);
            end
            for (int i = 0; i < NUM_PHYS_FUNC; i++) begin
                if (wr_commit && wr_qmap_hit[i]) begin
                    qmap[i] <= merge_bytes(qmap[i], wr_data, wr_strb);
                end
            end
            errcnt <= errcnt_next;
        end
    end

    // Read data is captured from the pre-update registers, so a colliding write is not visible yet.
    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_resp;
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_PHYS_FUNC; g++) begin : g_qmap_out
        assign q_base[g*16 +: 16] = qmap[g][31:16];
        assign q_num[g*16 +: 16]  = qmap[g][15:0];
    end

endmodule
